blit_engine: RTL and testbench

BLIT_ENGINE -- requirements
Module: blit_engine

---
 rtl/blit_engine.sv | 177 +++++++++++++++++
 tb/tb_blit_engine.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/blit_engine.sv
// blit_engine: screen copy, tile copy (optionally mirrored) or solid fill into a clipped destination frame.
// Latency: read issued with rd_en, pixel presented one cycle later; finished pulses N+2 cycles after go.
// Backpressure: none; one pixel per RUN cycle, go is ignored until the engine is back in IDLE.
module blit_engine #(
  parameter int SCREEN_W = 320,
  parameter int SCREEN_H = 240,
  parameter int TILE_W = 16,
  parameter int TILE_H = 16,
  parameter int SHEET_TILES_X = 4,
  parameter int CB = 6,
  parameter logic [CB-1:0] TRANSPARENT = 6'b001100,
  parameter int XW = 9,
  parameter int YW = 8,
  parameter int TSW = 4,
  parameter int AW = 17
) (
  input  logic           clk,
  input  logic           reset_n,
  input  logic           go,
  input  logic [1:0]     mode,
  input  logic [XW-1:0]  x,
  input  logic [YW-1:0]  y,
  input  logic [TSW-1:0] tile_select,
  input  logic           flip_x,
  input  logic [CB-1:0]  fill_colour,
  output logic [AW-1:0]  rd_addr,
  output logic           rd_en,
  input  logic [CB-1:0]  rd_data,
  output logic [XW-1:0]  x_out,
  output logic [YW-1:0]  y_out,
  output logic [CB-1:0]  colour,
  output logic           write_en,
  output logic           busy,
  output logic           finished
);

  localparam int SHEET_W = TILE_W * SHEET_TILES_X;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t         state;
  logic [1:0]     mode_l;
  logic [XW-1:0]  x_l;
  logic [YW-1:0]  y_l;
  logic [TSW-1:0] ts_l;
  logic           fx_l;
  logic [CB-1:0]  fill_l;
  logic [XW-1:0]  cx, ncx, w_m1;
  logic [YW-1:0]  cy, ncy, h_m1;
  logic           last, issue;
  logic [XW:0]    sum_x;
  logic [YW:0]    sum_y;
  logic           p_vld, p_inb, p_fill;

  // Source address of a region pixel; screen copy is linear, tile copy indexes into the sheet.
  function automatic logic [AW-1:0] addr_of(input logic [1:0] m, input logic [TSW-1:0] ts,
                                            input logic fx, input logic [XW-1:0] px,
                                            input logic [YW-1:0] py);
    logic [31:0] a, sx, tr, tc;
    tr = 32'(ts) / SHEET_TILES_X;
    tc = 32'(ts) % SHEET_TILES_X;
    sx = fx ? (TILE_W - 1 - 32'(px)) : 32'(px);
    if (m == 2'b00) a = 32'(py) * SCREEN_W + 32'(px);
    else            a = (tr * TILE_H + 32'(py)) * SHEET_W + tc * TILE_W + sx;
    return AW'(a);
  endfunction

  // Region bounds for the latched mode and the next raster position (cx runs fastest).
  always_comb begin
    w_m1 = (mode_l == 2'b00) ? XW'(SCREEN_W - 1) : XW'(TILE_W - 1);
    h_m1 = (mode_l == 2'b00) ? YW'(SCREEN_H - 1) : YW'(TILE_H - 1);
    last = (cx == w_m1) && (cy == h_m1);
    if (cx == w_m1) begin
      ncx = '0;
      ncy = cy + YW'(1);
    end else begin
      ncx = cx + XW'(1);
      ncy = cy;
    end
  end

  // A pixel is issued every RUN cycle except for the reserved (empty) mode.
  assign issue = (state == RUN) && (mode_l != 2'b11);
  assign sum_x = {1'b0, x_l} + {1'b0, cx};
  assign sum_y = {1'b0, y_l} + {1'b0, cy};

  // Control FSM: latches the request, walks the region and drives the registered read port.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      mode_l   <= '0;
      x_l      <= '0;
      y_l      <= '0;
      ts_l     <= '0;
      fx_l     <= 1'b0;
      fill_l   <= '0;
      cx       <= '0;
      cy       <= '0;
      rd_en    <= 1'b0;
      rd_addr  <= '0;
      busy     <= 1'b0;
      finished <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (go) begin
            state   <= RUN;
            busy    <= 1'b1;
            mode_l  <= mode;
            x_l     <= x;
            y_l     <= y;
            ts_l    <= tile_select;
            fx_l    <= flip_x;
            fill_l  <= fill_colour;
            cx      <= '0;
            cy      <= '0;
            rd_en   <= ~mode[1];
            rd_addr <= mode[1] ? '0 : addr_of(mode, tile_select, flip_x, XW'(0), YW'(0));
          end
        end
        RUN: begin
          if (mode_l == 2'b11 || last) begin
            state   <= DRAIN;
            rd_en   <= 1'b0;
            rd_addr <= '0;
            cx      <= '0;
            cy      <= '0;
          end else begin
            cx      <= ncx;
            cy      <= ncy;
            rd_addr <= mode_l[1] ? '0 : addr_of(mode_l, ts_l, fx_l, ncx, ncy);
          end
        end
        DRAIN: begin
          state    <= DONE;
          finished <= 1'b1;
        end
        DONE: begin
          state    <= IDLE;
          finished <= 1'b0;
          busy     <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Write stage: captures destination coordinates and clip result of the pixel issued this cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      p_vld  <= 1'b0;
      p_inb  <= 1'b0;
      p_fill <= 1'b0;
      x_out  <= '0;
      y_out  <= '0;
    end else begin
      p_vld <= issue;
      if (issue) begin
        x_out  <= sum_x[XW-1:0];
        y_out  <= sum_y[YW-1:0];
        p_inb  <= (sum_x < (XW+1)'(SCREEN_W)) && (sum_y < (YW+1)'(SCREEN_H));
        p_fill <= (mode_l == 2'b10);
      end
    end
  end

  // Colour arrives with the read data; the colour key only applies to copied pixels.
  always_comb begin
    colour   = '0;
    write_en = 1'b0;
    if (p_vld) begin
      colour   = p_fill ? fill_l : rd_data;
      write_en = p_inb && (p_fill || colour != TRANSPARENT);
    end
  end

endmodule

// File: tb/tb_blit_engine.sv
// tb_blit_engine: scoreboard bench for blit_engine; expected pixels are queued at issue and popped at write.
// Latency: checks issue in cycles 1..N, writes in 2..N+1, finished in N+2 relative to the go edge.
// Backpressure: none; bench mimics a 1-cycle-latency source memory.
module tb_blit_engine;

  localparam logic [5:0] KEY = 6'b001100;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        go;
  logic [1:0]  mode;
  logic [8:0]  x;
  logic [7:0]  y;
  logic [3:0]  tile_select;
  logic        flip_x;
  logic [5:0]  fill_colour;
  logic [16:0] rd_addr;
  logic        rd_en;
  logic [5:0]  rd_data = 6'h00;
  logic [8:0]  x_out;
  logic [7:0]  y_out;
  logic [5:0]  colour;
  logic        write_en;
  logic        busy;
  logic        finished;

  int errors = 0;
  int checks = 0;
  bit key_even = 1'b0;

  int n_rd, n_wr, fin_cyc, first_addr, last_addr, first_wx, first_wy;

  typedef struct {
    logic [8:0] x;
    logic [7:0] y;
    logic [5:0] col;
    bit         we;
  } pix_t;

  pix_t sb[$];

  blit_engine dut (
    .clk(clk), .reset_n(reset_n), .go(go), .mode(mode), .x(x), .y(y),
    .tile_select(tile_select), .flip_x(flip_x), .fill_colour(fill_colour),
    .rd_addr(rd_addr), .rd_en(rd_en), .rd_data(rd_data),
    .x_out(x_out), .y_out(y_out), .colour(colour), .write_en(write_en),
    .busy(busy), .finished(finished)
  );

  always #5 clk = ~clk;

  function automatic logic [5:0] mem_val(input int a);
    logic [31:0] av;
    av = a;
    if (key_even && !av[0]) return KEY;
    return {av[5:1], 1'b1};
  endfunction

  // Source memory: one-cycle read latency.
  always @(posedge clk) rd_data <= rd_en ? mem_val(int'(rd_addr)) : 6'h00;

  task automatic run_blit(input string nm, input logic [1:0] m, input int ox, input int oy,
                          input int ts, input bit fx, input logic [5:0] fc,
                          input bit keep_go, input bit no_wait,
                          output int o_rd, output int o_wr, output int o_fin,
                          output int o_fa, output int o_la, output int o_wx, output int o_wy);
    int w, h, n, last_c, i, cxm, cym, ea, ex, ey, tr, tc, sx, fin_cnt;
    int m_rd, m_addr, m_we, m_pix, m_fin, m_busy;
    bit exp_rd;
    pix_t e, p;
    w = (m == 2'b00) ? 320 : 16;
    h = (m == 2'b00) ? 240 : 16;
    n = (m == 2'b11) ? 0 : w * h;
    last_c = (m == 2'b11) ? 6 : n + 3;
    o_rd = 0; o_wr = 0; o_fin = -1; o_fa = -1; o_la = -1; o_wx = -1; o_wy = -1;
    m_rd = 0; m_addr = 0; m_we = 0; m_pix = 0; m_fin = 0; m_busy = 0; fin_cnt = 0;
    ea = 0;
    sb.delete();
    if (!no_wait) @(negedge clk);
    mode = m; x = ox[8:0]; y = oy[7:0]; tile_select = ts[3:0]; flip_x = fx; fill_colour = fc;
    go = 1'b1;
    @(posedge clk);
    for (int c = 1; c <= last_c; c++) begin
      @(negedge clk);
      e.x = '0; e.y = '0; e.col = '0; e.we = 1'b0;
      if (c >= 2 && c <= n + 1 && sb.size() > 0) e = sb.pop_front();
      if (write_en !== e.we) m_we++;
      if (write_en === 1'b1) begin
        o_wr++;
        if (o_wx < 0) begin o_wx = int'(x_out); o_wy = int'(y_out); end
        if (e.we && (x_out !== e.x || y_out !== e.y || colour !== e.col)) m_pix++;
      end
      exp_rd = 1'b0;
      if (c <= n) begin
        i = c - 1; cxm = i % w; cym = i / w;
        if (m == 2'b00) ea = cym * 320 + cxm;
        else begin
          tr = ts / 4; tc = ts % 4; sx = fx ? 15 - cxm : cxm;
          ea = (tr * 16 + cym) * 64 + tc * 16 + sx;
        end
        exp_rd = (m != 2'b10);
        ex = ox + cxm; ey = oy + cym;
        p.x = ex[8:0]; p.y = ey[7:0];
        p.col = (m == 2'b10) ? fc : mem_val(ea);
        p.we = (ex < 320) && (ey < 240) && (m == 2'b10 || p.col != KEY);
        sb.push_back(p);
      end
      if (rd_en !== exp_rd) m_rd++;
      if (rd_en === 1'b1) begin
        o_rd++;
        if (o_fa < 0) o_fa = int'(rd_addr);
        o_la = int'(rd_addr);
        if (exp_rd && rd_addr !== ea[16:0]) m_addr++;
      end
      if (finished === 1'b1) begin
        fin_cnt++;
        if (o_fin < 0) o_fin = c;
      end
      if (m != 2'b11) begin
        if (finished !== (c == n + 2)) m_fin++;
        if (busy !== (c <= n + 2)) m_busy++;
      end else if (c == last_c && busy !== 1'b0) m_busy++;
      if (c == 1) begin
        mode = 2'($urandom); x = 9'($urandom); y = 8'($urandom);
        tile_select = 4'($urandom); flip_x = 1'($urandom); fill_colour = 6'($urandom);
        go = keep_go;
      end
    end
    checks++; if (m_rd !== 0) begin errors++; $display("FAIL %s rd_en: %0d wrong cycles, required 0", nm, m_rd); end
    checks++; if (m_addr !== 0) begin errors++; $display("FAIL %s rd_addr: %0d wrong addresses, required 0", nm, m_addr); end
    checks++; if (m_we !== 0) begin errors++; $display("FAIL %s write_en: %0d wrong cycles, required 0", nm, m_we); end
    checks++; if (m_pix !== 0) begin errors++; $display("FAIL %s pixel: %0d wrong x/y/colour, required 0", nm, m_pix); end
    checks++; if (m_fin !== 0) begin errors++; $display("FAIL %s finished: %0d wrong cycles, required 0", nm, m_fin); end
    checks++; if (m_busy !== 0) begin errors++; $display("FAIL %s busy: %0d wrong cycles, required 0", nm, m_busy); end
    checks++; if (fin_cnt !== 1) begin errors++; $display("FAIL %s finished_count: got %0d, required 1", nm, fin_cnt); end
  endtask

  task automatic test_reset();
    checks++; if (rd_en !== 1'b0 || write_en !== 1'b0) begin errors++; $display("FAIL reset_en: rd_en=%b write_en=%b, required 0 0", rd_en, write_en); end
    checks++; if (busy !== 1'b0 || finished !== 1'b0) begin errors++; $display("FAIL reset_status: busy=%b finished=%b, required 0 0", busy, finished); end
    checks++; if (rd_addr !== 17'd0) begin errors++; $display("FAIL reset_addr: got %0d, required 0", rd_addr); end
    checks++; if (x_out !== 9'd0 || y_out !== 8'd0 || colour !== 6'd0) begin errors++; $display("FAIL reset_pixel: got %0d,%0d,%h, required 0,0,0", x_out, y_out, colour); end
  endtask

  task automatic test_tile_copy();
    key_even = 1'b0;
    run_blit("tile", 2'b01, 100, 50, 5, 1'b0, 6'h00, 1'b0, 1'b0, n_rd, n_wr, fin_cyc, first_addr, last_addr, first_wx, first_wy);
    checks++; if (first_addr !== 1040) begin errors++; $display("FAIL tile_first_addr: got %0d, required 1040", first_addr); end
    checks++; if (first_wx !== 100 || first_wy !== 50) begin errors++; $display("FAIL tile_first_write: got (%0d,%0d), required (100,50)", first_wx, first_wy); end
    checks++; if (n_rd !== 256) begin errors++; $display("FAIL tile_issues: got %0d, required 256", n_rd); end
    checks++; if (fin_cyc !== 258) begin errors++; $display("FAIL tile_finish_cycle: got %0d, required 258", fin_cyc); end
  endtask

  task automatic test_tile_flip();
    key_even = 1'b0;
    run_blit("flip", 2'b01, 100, 50, 5, 1'b1, 6'h00, 1'b0, 1'b0, n_rd, n_wr, fin_cyc, first_addr, last_addr, first_wx, first_wy);
    checks++; if (first_addr !== 1055) begin errors++; $display("FAIL flip_first_addr: got %0d, required 1055", first_addr); end
    checks++; if (last_addr !== 2000) begin errors++; $display("FAIL flip_last_addr: got %0d, required 2000", last_addr); end
    checks++; if (n_wr !== 256) begin errors++; $display("FAIL flip_writes: got %0d, required 256", n_wr); end
  endtask

  task automatic test_fill_clip();
    key_even = 1'b0;
    run_blit("fill", 2'b10, 312, 232, 3, 1'b0, KEY, 1'b0, 1'b0, n_rd, n_wr, fin_cyc, first_addr, last_addr, first_wx, first_wy);
    checks++; if (n_wr !== 64) begin errors++; $display("FAIL fill_writes: got %0d, required 64", n_wr); end
    checks++; if (n_rd !== 0) begin errors++; $display("FAIL fill_reads: got %0d, required 0", n_rd); end
    checks++; if (first_wx !== 312 || first_wy !== 232) begin errors++; $display("FAIL fill_first_write: got (%0d,%0d), required (312,232)", first_wx, first_wy); end
  endtask

  task automatic test_screen_copy();
    key_even = 1'b1;
    run_blit("screen", 2'b00, 0, 0, 0, 1'b0, 6'h00, 1'b0, 1'b0, n_rd, n_wr, fin_cyc, first_addr, last_addr, first_wx, first_wy);
    checks++; if (n_rd !== 76800) begin errors++; $display("FAIL screen_issues: got %0d, required 76800", n_rd); end
    checks++; if (fin_cyc !== 76802) begin errors++; $display("FAIL screen_finish_cycle: got %0d, required 76802", fin_cyc); end
    checks++; if (n_wr !== 38400) begin errors++; $display("FAIL screen_writes: got %0d, required 38400", n_wr); end
    checks++; if (first_wx !== 1 || first_wy !== 0) begin errors++; $display("FAIL screen_first_write: got (%0d,%0d), required (1,0)", first_wx, first_wy); end
    key_even = 1'b0;
  endtask

  task automatic test_reserved();
    run_blit("reserved", 2'b11, 5, 5, 1, 1'b0, 6'h00, 1'b0, 1'b0, n_rd, n_wr, fin_cyc, first_addr, last_addr, first_wx, first_wy);
    checks++; if (n_rd !== 0 || n_wr !== 0) begin errors++; $display("FAIL reserved_activity: reads=%0d writes=%0d, required 0 0", n_rd, n_wr); end
  endtask

  task automatic test_back_to_back();
    run_blit("b2b_a", 2'b01, 10, 20, 0, 1'b1, 6'h00, 1'b1, 1'b0, n_rd, n_wr, fin_cyc, first_addr, last_addr, first_wx, first_wy);
    checks++; if (fin_cyc !== 258) begin errors++; $display("FAIL b2b_a_finish: got %0d, required 258", fin_cyc); end
    run_blit("b2b_b", 2'b10, 300, 230, 0, 1'b0, 6'h2A, 1'b1, 1'b1, n_rd, n_wr, fin_cyc, first_addr, last_addr, first_wx, first_wy);
    checks++; if (n_wr !== 160) begin errors++; $display("FAIL b2b_b_writes: got %0d, required 160", n_wr); end
    run_blit("b2b_c", 2'b01, 0, 0, 15, 1'b0, 6'h00, 1'b0, 1'b1, n_rd, n_wr, fin_cyc, first_addr, last_addr, first_wx, first_wy);
    checks++; if (first_addr !== 3120) begin errors++; $display("FAIL b2b_c_first_addr: got %0d, required 3120", first_addr); end
  endtask

  task automatic test_reset_mid();
    int bad;
    bad = 0;
    @(negedge clk);
    mode = 2'b01; x = 9'd100; y = 8'd50; tile_select = 4'd5; flip_x = 1'b0; fill_colour = 6'h00;
    go = 1'b1;
    @(posedge clk);
    for (int c = 1; c <= 100; c++) begin
      @(negedge clk);
      if (c == 1) go = 1'b0;
    end
    checks++; if (rd_en !== 1'b1 || busy !== 1'b1) begin errors++; $display("FAIL midrun_active: rd_en=%b busy=%b, required 1 1", rd_en, busy); end
    reset_n = 1'b0;
    #1;
    checks++; if (rd_en !== 1'b0 || write_en !== 1'b0 || busy !== 1'b0 || finished !== 1'b0) begin
      errors++; $display("FAIL async_reset_ctl: rd_en=%b write_en=%b busy=%b finished=%b, required 0 0 0 0", rd_en, write_en, busy, finished);
    end
    checks++; if (rd_addr !== 17'd0 || x_out !== 9'd0 || y_out !== 8'd0 || colour !== 6'd0) begin
      errors++; $display("FAIL async_reset_data: addr=%0d x=%0d y=%0d colour=%h, required 0", rd_addr, x_out, y_out, colour);
    end
    repeat (3) begin
      @(negedge clk);
      if (write_en !== 1'b0 || finished !== 1'b0 || busy !== 1'b0) bad++;
    end
    checks++; if (bad !== 0) begin errors++; $display("FAIL reset_hold: %0d active cycles, required 0", bad); end
    reset_n = 1'b1;
    run_blit("after_reset", 2'b01, 100, 50, 5, 1'b0, 6'h00, 1'b0, 1'b1, n_rd, n_wr, fin_cyc, first_addr, last_addr, first_wx, first_wy);
    checks++; if (fin_cyc !== 258 || first_addr !== 1040) begin errors++; $display("FAIL after_reset_blit: finish=%0d addr=%0d, required 258 1040", fin_cyc, first_addr); end
  endtask

  initial begin
    reset_n = 1'b0; go = 1'b0; mode = 2'b00; x = '0; y = '0;
    tile_select = '0; flip_x = 1'b0; fill_colour = '0;
    #22;
    test_reset();
    @(negedge clk);
    reset_n = 1'b1;
    test_tile_copy();
    test_tile_flip();
    test_fill_clip();
    test_reserved();
    test_back_to_back();
    test_reset_mid();
    test_screen_copy();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
